hazard_ctrl: RTL

- Central hazard controller for the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards and sequences a multi-cycle multiply/divide occupancy.
- Drives the stall/flush controls of the IF/ID and ID/EX pipeline registers and the forwarding muxes in ID and EX.
- Keeps saturating stall/flush event counters for debug.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Forward-select codes, register-zero constant, mul/div FSM state type.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    // True when a real (non-$0) register matches another specifier.
    function automatic logic reg_hit(input logic [4:0] a,
                                     input logic [4:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for debug event counts.
// Ports: clk, reset (sync, active-high), inc (count enable), count (value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: forwarding selects, load-use and branch
// stalls, mul/div occupancy sequencing and saturating debug counters.
// Inputs: ID/EX/MEM/WB register specifiers and write/load flags,
//   BranchD, PCSrcD, MulDivStartE; clk and sync active-high reset.
// Outputs: StallF/D/E, FlushD/E, ForwardA/BD, ForwardA/BE,
//   MulDivBusy, StallCount, FlushCount.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             MulDivStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             StallE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int MCW = $clog2(MULDIV_CYCLES + 1);
    localparam logic [MCW-1:0] MD_LOAD = MCW'(MULDIV_CYCLES - 1);
    localparam logic [MCW-1:0] MD_ONE  = MCW'(1);

    md_state_e      state, state_n;
    logic [MCW-1:0] md_cnt, md_cnt_n;
    logic           md_start;
    logic           md_last;

    logic           lwstall;
    logic           branchstall;
    logic           hold;
    logic           busy;
    logic           stall_e;
    logic [1:0]     fwd_ae;
    logic [1:0]     fwd_be;

    // EX operand select: MEM result is younger, so it wins over WB.
    function automatic logic [1:0] ex_fwd(input logic [4:0] src,
                                          input logic       wr_m,
                                          input logic [4:0] dst_m,
                                          input logic       wr_w,
                                          input logic [4:0] dst_w);
        if (wr_m && reg_hit(src, dst_m)) return FWD_MEM;
        if (wr_w && reg_hit(src, dst_w)) return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_ae = ex_fwd(RsE, RegWriteM, WriteRegM,
                        RegWriteW, WriteRegW);
        fwd_be = ex_fwd(RtE, RegWriteM, WriteRegM,
                        RegWriteW, WriteRegW);
    end

    // A load's destination in EX is RtE.
    assign lwstall = MemtoRegE &&
                     (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));

    // Branch compares in ID, so any result not yet in MEM stalls it,
    // as does a load still in MEM.
    assign branchstall = BranchD && (
        (RegWriteE && (reg_hit(WriteRegE, RsD) ||
                       reg_hit(WriteRegE, RtD))) ||
        (MemtoRegM && (reg_hit(WriteRegM, RsD) ||
                       reg_hit(WriteRegM, RtD))));

    assign hold = lwstall || branchstall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_n;
            md_cnt <= md_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        md_cnt_n = md_cnt;
        md_start = 1'b0;
        md_last  = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (MulDivStartE) begin
                    state_n  = MD_BUSY;
                    md_cnt_n = MD_LOAD;
                    md_start = 1'b1;
                end
            end
            MD_BUSY: begin
                md_cnt_n = md_cnt - 1'b1;
                if (md_cnt == MD_ONE) begin
                    md_last = 1'b1;
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    assign busy = md_start || (state == MD_BUSY);

    // The final busy cycle lets EX drain so the result moves on.
    assign stall_e = busy && !md_last;

    always_comb begin
        StallE     = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushE     = 1'b1;
        FlushD     = 1'b0;
        ForwardAD  = 1'b0;
        ForwardBD  = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        MulDivBusy = 1'b0;
        if (!reset) begin
            StallE     = stall_e;
            StallF     = hold || stall_e;
            StallD     = hold || stall_e;
            // No bubble while EX is frozen: it would overwrite the held op.
            FlushE     = hold && !stall_e;
            FlushD     = PCSrcD && !(hold || stall_e);
            ForwardAD  = RegWriteM && reg_hit(RsD, WriteRegM);
            ForwardBD  = RegWriteM && reg_hit(RtD, WriteRegM);
            ForwardAE  = fwd_ae;
            ForwardBE  = fwd_be;
            MulDivBusy = busy;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (FlushCount)
    );

endmodule
